fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage cached pipeline.
- Keeps its own shadow copy of the destination-register fields for the EX, MEM and WB stages.
- Drives the 2-bit select of both EX-stage operand forwarding muxes. Encoding: 00 = ID/EX register data, 01 = WB write data, 10 = MEM ALU result.
- Generates load-use stall and bubble insertion, and freezes its tracking during data-cache miss stalls.

---
 rtl/fwd_hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use/freeze hazard controller for the 5-stage pipeline.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    output logic [SEL_W-1:0]  fwd_a_o,
    output logic [SEL_W-1:0]  fwd_b_o,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [31:0]       lu_stall_cnt_o,
    output logic [31:0]       freeze_cnt_o
);

    localparam logic [SEL_W-1:0] SEL_ID  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);

    typedef enum logic [1:0] {RUN, LU_STALL, FREEZE} state_t;

    state_t state_q, state_d;
    logic   flush_pend_q, flush_pend_d;

    logic              ex_valid_q, ex_valid_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic              mem_valid_q, mem_valid_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_regwrite_q, mem_regwrite_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic              wb_regwrite_q, wb_regwrite_d;

    logic flush_any;
    logic lu;

    function automatic logic [SEL_W-1:0] fwd_sel(
        input logic              ex_v,
        input logic [REG_AW-1:0] rs,
        input logic              m_v,
        input logic              m_rw,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_v,
        input logic              w_rw,
        input logic [REG_AW-1:0] w_rd
    );
        logic [SEL_W-1:0] sel;
        sel = SEL_ID;
        if (ex_v) begin
            if (m_v && m_rw && (m_rd != '0) && (m_rd == rs))
                sel = SEL_MEM;
            else if (w_v && w_rw && (w_rd != '0) && (w_rd == rs))
                sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        flush_any = flush_i | flush_pend_q;
        lu = ex_valid_q && ex_memread_q && (ex_rd_q != '0) && id_valid_i &&
             ((ex_rd_q == id_rs1_i) || (ex_rd_q == id_rs2_i));
    end

    // Selects depend only on registered slots, so they hold naturally while frozen.
    always_comb begin
        fwd_a_o = fwd_sel(ex_valid_q, ex_rs1_q, mem_valid_q, mem_regwrite_q, mem_rd_q,
                          wb_valid_q, wb_regwrite_q, wb_rd_q);
        fwd_b_o = fwd_sel(ex_valid_q, ex_rs2_q, mem_valid_q, mem_regwrite_q, mem_rd_q,
                          wb_valid_q, wb_regwrite_q, wb_rd_q);
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    // FSM: next state; leaving FREEZE re-evaluates flush/lu like RUN
    always_comb begin
        state_d = RUN;
        if (mem_stall_i)
            state_d = FREEZE;
        else if (flush_any)
            state_d = RUN;
        else if (lu && state_q != LU_STALL)
            state_d = LU_STALL;
    end

    // FSM: outputs
    always_comb begin
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        if (mem_stall_i) begin
            stall_o = 1'b1;
        end else if (flush_any) begin
            bubble_o = 1'b1;
        end else if (lu && state_q != LU_STALL) begin
            stall_o  = 1'b1;
            bubble_o = 1'b1;
        end
    end

    always_comb begin
        flush_pend_d = flush_pend_q;
        if (mem_stall_i) begin
            if (flush_i) flush_pend_d = 1'b1;
        end else if (flush_any) begin
            flush_pend_d = 1'b0;
        end
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        ex_regwrite_d  = ex_regwrite_q;
        ex_memread_d   = ex_memread_q;
        mem_valid_d    = mem_valid_q;
        mem_rd_d       = mem_rd_q;
        mem_regwrite_d = mem_regwrite_q;
        wb_valid_d     = wb_valid_q;
        wb_rd_d        = wb_rd_q;
        wb_regwrite_d  = wb_regwrite_q;
        if (!mem_stall_i) begin
            wb_valid_d     = mem_valid_q;
            wb_rd_d        = mem_rd_q;
            wb_regwrite_d  = mem_regwrite_q;
            mem_valid_d    = ex_valid_q;
            mem_rd_d       = ex_rd_q;
            mem_regwrite_d = ex_regwrite_q;
            ex_valid_d     = id_valid_i & ~bubble_o;
            ex_rs1_d       = id_rs1_i;
            ex_rs2_d       = id_rs2_i;
            ex_rd_d        = id_rd_i;
            ex_regwrite_d  = id_regwrite_i;
            ex_memread_d   = id_memread_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_pend_q   <= 1'b0;
            ex_valid_q     <= 1'b0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
        end else begin
            flush_pend_q   <= flush_pend_d;
            ex_valid_q     <= ex_valid_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_valid_q    <= mem_valid_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_regwrite_q  <= wb_regwrite_d;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] lu_stall_cnt_q, lu_stall_cnt_d;
    logic [31:0] freeze_cnt_q, freeze_cnt_d;

    always_comb begin
        lu_stall_cnt_d = lu_stall_cnt_q;
        freeze_cnt_d   = freeze_cnt_q;
        if (state_d == LU_STALL) lu_stall_cnt_d = lu_stall_cnt_q + 32'd1;
        if (mem_stall_i)         freeze_cnt_d   = freeze_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lu_stall_cnt_q <= '0;
            freeze_cnt_q   <= '0;
        end else begin
            lu_stall_cnt_q <= lu_stall_cnt_d;
            freeze_cnt_q   <= freeze_cnt_d;
        end
    end

    assign lu_stall_cnt_o = lu_stall_cnt_q;
    assign freeze_cnt_o   = freeze_cnt_q;
`else
    assign lu_stall_cnt_o = 32'd0;
    assign freeze_cnt_o   = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding, load-use, freeze/flush and reset.
module tb_fwd_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic       id_regwrite_i, id_memread_i;
    logic       mem_stall_i, flush_i;
    logic [1:0] fwd_a_o, fwd_b_o;
    logic       stall_o, bubble_o;
    logic [31:0] lu_stall_cnt_o, freeze_cnt_o;

    int errors = 0;
    int checks = 0;
    int exp_lu = 0;
    int exp_fr = 0;

    always #5 clk_i = ~clk_i;

    fwd_hazard_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .mem_stall_i(mem_stall_i), .flush_i(flush_i),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o), .bubble_o(bubble_o),
        .lu_stall_cnt_o(lu_stall_cnt_o), .freeze_cnt_o(freeze_cnt_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_regwrite_i = rw; id_memread_i = mr;
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; mem_stall_i = 1'b0; flush_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        tick; tick;
        rst_i = 1'b0;
        #1;
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL rst_fwd_a got=%b exp=00", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL rst_fwd_b got=%b exp=00", fwd_b_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
        checks++; if (bubble_o !== 1'b0) begin errors++; $display("FAIL rst_bubble got=%b exp=0", bubble_o); end
        checks++; if (lu_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_lu_cnt got=%0d exp=0", lu_stall_cnt_o); end
        checks++; if (freeze_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_fr_cnt got=%0d exp=0", freeze_cnt_o); end
    endtask

    task automatic test_fwd_mem_wb;
        set_id(1, 1, 2, 5, 1, 0);       // add x5
        tick;
        set_id(1, 5, 0, 6, 1, 0);       // reads x5 on rs1
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_no_stall got=%b exp=0", stall_o); end
        tick;
        set_id(1, 9, 5, 0, 0, 0);       // reads x5 on rs2
        checks++; if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL fwd_a_mem got=%b exp=10", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL fwd_b_rs2zero got=%b exp=00", fwd_b_o); end
        tick;
        set_id(0, 0, 0, 0, 0, 0);
        checks++; if (fwd_b_o !== 2'b01) begin errors++; $display("FAIL fwd_b_wb got=%b exp=01", fwd_b_o); end
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL fwd_a_none got=%b exp=00", fwd_a_o); end
    endtask

    task automatic test_priority;
        set_id(1, 0, 0, 7, 1, 0); tick;
        set_id(1, 0, 0, 7, 1, 0); tick;
        set_id(1, 7, 0, 0, 0, 0); tick;
        checks++; if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL mem_priority got=%b exp=10", fwd_a_o); end
        set_id(1, 1, 0, 0, 1, 0); tick;  // writes x0
        set_id(1, 0, 0, 0, 0, 0); tick;
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL x0_no_fwd_a got=%b exp=00", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL x0_no_fwd_b got=%b exp=00", fwd_b_o); end
        set_id(0, 0, 0, 0, 0, 0); tick; tick;
    endtask

    task automatic test_load_use;
        set_id(1, 1, 0, 3, 1, 1);       // lw x3
        tick;
        set_id(1, 4, 3, 8, 1, 0);       // uses x3 on rs2
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall_o); end
        checks++; if (bubble_o !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%b exp=1", bubble_o); end
        tick;
        exp_lu++;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_one_cycle_stall got=%b exp=0", stall_o); end
        checks++; if (bubble_o !== 1'b0) begin errors++; $display("FAIL lu_one_cycle_bubble got=%b exp=0", bubble_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL lu_bubble_in_ex got=%b exp=00", fwd_b_o); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (lu_stall_cnt_o !== 32'(exp_lu)) begin errors++; $display("FAIL lu_cnt got=%0d exp=%0d", lu_stall_cnt_o, exp_lu); end
`else
        checks++; if (lu_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL lu_cnt_off got=%0d exp=0", lu_stall_cnt_o); end
`endif
        tick;
        set_id(0, 0, 0, 0, 0, 0);
        // consumer in EX, load two stages ahead in WB
        checks++; if (fwd_b_o !== 2'b01) begin errors++; $display("FAIL lu_fwd_b got=%b exp=01", fwd_b_o); end
        tick; tick;
    endtask

    task automatic test_freeze;
        set_id(1, 1, 2, 5, 1, 0); tick;
        set_id(1, 5, 0, 6, 1, 0); tick;
        set_id(1, 2, 2, 9, 1, 0);
        mem_stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            flush_i = (k == 1);
            #1;
            checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL frz_stall k=%0d got=%b exp=1", k, stall_o); end
            checks++; if (bubble_o !== 1'b0) begin errors++; $display("FAIL frz_bubble k=%0d got=%b exp=0", k, bubble_o); end
            checks++; if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL frz_fwd_a k=%0d got=%b exp=10", k, fwd_a_o); end
            tick;
            exp_fr++;
        end
        mem_stall_i = 1'b0; flush_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL frz_exit_stall got=%b exp=0", stall_o); end
        checks++; if (bubble_o !== 1'b1) begin errors++; $display("FAIL frz_pend_flush got=%b exp=1", bubble_o); end
        checks++; if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL frz_slots_held got=%b exp=10", fwd_a_o); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (freeze_cnt_o !== 32'(exp_fr)) begin errors++; $display("FAIL fr_cnt got=%0d exp=%0d", freeze_cnt_o, exp_fr); end
`else
        checks++; if (freeze_cnt_o !== 32'd0) begin errors++; $display("FAIL fr_cnt_off got=%0d exp=0", freeze_cnt_o); end
`endif
        tick;
        checks++; if (bubble_o !== 1'b0) begin errors++; $display("FAIL pend_cleared got=%b exp=0", bubble_o); end
        set_id(0, 0, 0, 0, 0, 0); tick; tick;
    endtask

    task automatic test_lu_flush;
        set_id(1, 1, 0, 3, 1, 1); tick;           // lw x3
        set_id(1, 3, 3, 8, 1, 0);
        flush_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL luflush_stall got=%b exp=0", stall_o); end
        checks++; if (bubble_o !== 1'b1) begin errors++; $display("FAIL luflush_bubble got=%b exp=1", bubble_o); end
        tick;
        flush_i = 1'b0;
        set_id(1, 1, 0, 0, 1, 1);                 // lw x0 enters EX behind the flushed slot
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL luflush_no_lustall got=%b exp=0", stall_o); end
        tick;
        set_id(1, 0, 0, 4, 1, 0);                 // reads x0 behind lw x0
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lw_x0_no_stall got=%b exp=0", stall_o); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (lu_stall_cnt_o !== 32'(exp_lu)) begin errors++; $display("FAIL luflush_cnt got=%0d exp=%0d", lu_stall_cnt_o, exp_lu); end
`endif
        tick;
        set_id(0, 0, 0, 0, 0, 0); tick;
    endtask

    task automatic test_reset_in_freeze;
        set_id(1, 1, 2, 5, 1, 0); tick;
        set_id(1, 5, 5, 6, 1, 0); tick;
        set_id(1, 2, 2, 9, 1, 0);
        mem_stall_i = 1'b1; flush_i = 1'b1; tick;
        flush_i = 1'b0; tick;
        rst_i = 1'b1; tick;
        rst_i = 1'b0; mem_stall_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        exp_lu = 0; exp_fr = 0;
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL rstfrz_fwd_a got=%b exp=00", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL rstfrz_fwd_b got=%b exp=00", fwd_b_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rstfrz_stall got=%b exp=0", stall_o); end
        checks++; if (bubble_o !== 1'b0) begin errors++; $display("FAIL rstfrz_bubble got=%b exp=0", bubble_o); end
        checks++; if (lu_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rstfrz_lu_cnt got=%0d exp=0", lu_stall_cnt_o); end
        checks++; if (freeze_cnt_o !== 32'd0) begin errors++; $display("FAIL rstfrz_fr_cnt got=%0d exp=0", freeze_cnt_o); end
    endtask

    initial begin
        test_reset;
        test_fwd_mem_wb;
        test_priority;
        test_load_use;
        test_freeze;
        test_lu_flush;
        test_reset_in_freeze;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
